// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage data memory.
// Geometry: DEPTH doublewords of XLEN bits, byte space MEM_BYTES.
package mem_pkg;

    localparam int DEPTH     = 1024;
    localparam int XLEN      = 64;
    localparam int REG_AW    = 5;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * 8;

endpackage : mem_pkg

// File: rtl/dmem_array.sv
// Doubleword data memory: async clear, one write port, one combinational
// read port, plus address range decode.
// Build option: MEM_ALIGN_CHECK_EN makes any access with addr[2:0] != 0
// out of range (load reads 0, store dropped). Default build ignores addr[2:0].
module dmem_array
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             wr_en_d;

    // Address decode: word index and range qualification.
    always_comb begin
        idx      = addr[IDX_W+2:3];
        in_range = (addr < XLEN'(MEM_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
        in_range = in_range && (addr[2:0] == 3'b000);
`endif
        wr_en_d  = we && in_range;
    end

    // Storage: whole array clears while reset is low, stores on rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[idx] <= wdata;
        end
    end

    // Combinational read; out-of-range addresses read as zero.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            rdata = mem_q[idx];
        end
    end

endmodule : dmem_array

// File: rtl/memory_stage.sv
// MEM stage of the sequential RV64 core: data memory access addressed by
// the ALU result, with WB control, Rd and ALU result passed straight through.
// Build option: MEM_ALIGN_CHECK_EN (see dmem_array) rejects misaligned accesses.
module memory_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic [XLEN-1:0]   WriteData,
    input  logic [REG_AW-1:0] Rd,
    input  logic              Zero,
    input  logic              BranchTaken,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    output logic [XLEN-1:0]   ReadData,
    output logic [XLEN-1:0]   ALUResultOut,
    output logic [REG_AW-1:0] RdOut,
    output logic              BranchTakenOut,
    output logic              MemtoRegOut,
    output logic              RegWriteOut
);

    logic [XLEN-1:0] rd_word;
    logic            unused_zero;

    // The zero flag is consumed in EX; it arrives here only for bus symmetry.
    assign unused_zero = Zero;

    dmem_array u_dmem (
        .clk   (clk),
        .reset (reset),
        .addr  (ALUResult),
        .wdata (WriteData),
        .we    (MemWrite),
        .rdata (rd_word)
    );

    // Load gating and zero-latency pass-through to write-back.
    always_comb begin
        ReadData       = MemRead ? rd_word : '0;
        ALUResultOut   = ALUResult;
        RdOut          = Rd;
        BranchTakenOut = BranchTaken;
        MemtoRegOut    = MemtoReg;
        RegWriteOut    = RegWrite;
    end

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [63:0] ALUResult, WriteData;
    logic [4:0]  Rd;
    logic        Zero, BranchTaken, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [63:0] ReadData, ALUResultOut;
    logic [4:0]  RdOut;
    logic        BranchTakenOut, MemtoRegOut, RegWriteOut;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        bt;
        logic        m2r;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [63:0] D_BEEF = 64'hDEADBEEFDEADBEEF;
    localparam logic [63:0] D_1234 = 64'h1234567890ABCDEF;
    localparam logic [63:0] D_AAAA = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] D_5555 = 64'h5555555555555555;
    localparam logic [63:0] D_FFFF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] D_BAD  = 64'h0000000000000BAD;
    localparam logic [63:0] D_77   = 64'h0000000000000077;
`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [63:0] EXP_MIS_RD = 64'h0;
    localparam logic [63:0] EXP_W2     = D_BEEF;
`else
    localparam logic [63:0] EXP_MIS_RD = D_BEEF;
    localparam logic [63:0] EXP_W2     = D_77;
`endif

    memory_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ALUResult      (ALUResult),
        .WriteData      (WriteData),
        .Rd             (Rd),
        .Zero           (Zero),
        .BranchTaken    (BranchTaken),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .ReadData       (ReadData),
        .ALUResultOut   (ALUResultOut),
        .RdOut          (RdOut),
        .BranchTakenOut (BranchTakenOut),
        .MemtoRegOut    (MemtoRegOut),
        .RegWriteOut    (RegWriteOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ReadData",       e.id, ReadData,             e.rdata);
            chk("ALUResultOut",   e.id, ALUResultOut,         e.alu);
            chk("RdOut",          e.id, {59'd0, RdOut},       {59'd0, e.rd});
            chk("BranchTakenOut", e.id, {63'd0, BranchTakenOut}, {63'd0, e.bt});
            chk("MemtoRegOut",    e.id, {63'd0, MemtoRegOut}, {63'd0, e.m2r});
            chk("RegWriteOut",    e.id, {63'd0, RegWriteOut}, {63'd0, e.rw});
        end
    end

    // Drive one vector for a full cycle (through the next rising edge).
    task automatic step(input int id, input logic [63:0] a, input logic [63:0] wd,
                        input logic [4:0] rd, input logic bt, input logic mr,
                        input logic mw, input logic m2r, input logic rw,
                        input logic [63:0] exp_rd);
        exp_t e;
        ALUResult   = a;
        WriteData   = wd;
        Rd          = rd;
        Zero        = (a == 64'd0);
        BranchTaken = bt;
        MemRead     = mr;
        MemWrite    = mw;
        MemtoReg    = m2r;
        RegWrite    = rw;
        e.id = id; e.rdata = exp_rd; e.alu = a; e.rd = rd;
        e.bt = bt; e.m2r = m2r; e.rw = rw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic store(input int id, input logic [63:0] a, input logic [63:0] wd);
        step(id, a, wd, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic load(input int id, input logic [63:0] a, input logic [63:0] exp_rd);
        step(id, a, 64'd0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        ALUResult = '0; WriteData = '0; Rd = '0; Zero = 1'b0; BranchTaken = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: reads zero, pass-through still live.
        step(0, 64'h10, D_FFFF, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0);
        reset = 1'b1;

        store(1, 64'h10, D_BEEF);
        load (2, 64'h10, D_BEEF);
        store(3, 64'h20, D_1234);
        load (4, 64'h20, D_1234);
        // Branch pass-through with MemRead low.
        step(5, 64'h30, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0);
        step(6, 64'h30, 64'h0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
        // Boundaries.
        store(7, 64'h0, D_AAAA);
        store(8, 64'h1FF8, D_5555);
        load (9, 64'h0, D_AAAA);
        load (10, 64'h1FF8, D_5555);
        // Out of range, including high address bits aliasing onto word 2.
        store(11, 64'h2000, D_FFFF);
        load (12, 64'h2000, 64'd0);
        load (13, 64'h0, D_AAAA);
        store(14, 64'h1_0000_0010, D_FFFF);
        load (15, 64'h10, D_BEEF);
        load (16, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
        // Read and write same word in one cycle: old data until the edge.
        step(17, 64'h20, D_BAD, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, D_1234);
        load (18, 64'h20, D_BAD);
        // MemRead low at a valid, written address.
        step(19, 64'h10, 64'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0);
        // Misaligned accesses.
        load (20, 64'h13, EXP_MIS_RD);
        store(21, 64'h15, D_77);
        load (22, 64'h10, EXP_W2);
        // Reset pulse between edges clears earlier contents.
        store(23, 64'h0, D_FFFF);
        load (24, 64'h0, D_FFFF);
        #3 reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        load (25, 64'h0, 64'd0);
        load (26, 64'h20, 64'd0);
        load (27, 64'h1FF8, 64'd0);
        // Store while reset is held low is lost.
        reset = 1'b0;
        step(28, 64'h8, D_5555, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd0);
        reset = 1'b1;
        load (29, 64'h8, 64'd0);

        MemWrite = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_memory_stage
